// File: rtl/pipeline_elastic_pkg.sv
// Shared helpers for the elastic pipeline: occupancy-counter width and
// elaboration-time parameter checks.
package pipeline_pkg;

  function automatic int count_width(int stages);
    return $clog2(stages + 1);
  endfunction

endpackage

`ifndef PIPELINE_CHECK_PARAM
// Expands to a generate block that stops elaboration when cond is false.
`define PIPELINE_CHECK_PARAM(blk, cond, msg) \
  if (!(cond)) begin : blk \
    $error(msg); \
  end
`endif

// File: rtl/pipeline_elastic_if.sv
// One valid/ready stream: a word moves on every rising edge where valid and
// ready are both 1; valid must not depend on ready, data is stable while valid.
interface pipeline_elastic_if
  import pipeline_pkg::*;
#(
  parameter int p_width = 32
) ();

  logic               valid;
  logic               ready;
  logic [p_width-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/pipeline_elastic_stage.sv
// One pipeline register: valid bit plus a data word that only captures when a
// valid word arrives. Exposes the next valid value for the occupancy counter.
module pipeline_elastic_stage
  import pipeline_pkg::*;
#(
  parameter int p_width = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               in_valid,
  input  logic [p_width-1:0] in_data,
  input  logic               load,
  input  logic               flush,
  output logic               valid,
  output logic [p_width-1:0] data,
  output logic               valid_nxt
);

  logic               valid_q, valid_d;
  logic [p_width-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = in_valid;
    end
    // Data only moves with a real word, so empty slots keep stale contents.
    if (load && in_valid && !flush) begin
      data_d = in_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid     = valid_q;
  assign data      = data_q;
  assign valid_nxt = valid_d;

endmodule

// File: rtl/pipeline_elastic.sv
// Elastic pipeline of p_stages valid/data registers. A stage advances when any
// stage at or beyond it is empty or the consumer is ready, so bubbles collapse.
module pipeline_elastic
  import pipeline_pkg::*;
#(
  parameter int p_width  = 32,
  parameter int p_stages = 8
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_valid,
  output logic                             o_ready,
  input  logic [p_width-1:0]               i_data,
  output logic                             o_valid,
  input  logic                             i_ready,
  output logic [p_width-1:0]               o_data,
  input  logic                             i_flush,
  output logic [count_width(p_stages)-1:0] o_count
);

  localparam int c_cnt_w = count_width(p_stages);

  `PIPELINE_CHECK_PARAM(g_chk_width, p_width >= 1, "pipeline_elastic: p_width must be >= 1")
  `PIPELINE_CHECK_PARAM(g_chk_stages, p_stages >= 1, "pipeline_elastic: p_stages must be >= 1")

  logic [p_stages-1:0] valid;
  logic [p_stages-1:0] valid_nxt;
  logic [p_stages-1:0] rdy;
  logic [p_width-1:0]  data [p_stages];
  logic [c_cnt_w-1:0]  count_q, count_d;

  // rdy[k] = "some stage at index >= k is empty, or the consumer takes a word";
  // built with a running OR from the output end to avoid a self-referencing vector.
  always_comb begin
    logic acc;
    acc = i_ready;
    rdy = '0;
    for (int k = p_stages - 1; k >= 0; k--) begin
      acc    = acc | ~valid[k];
      rdy[k] = acc;
    end
  end

  assign o_ready = rdy[0] & ~i_flush;

  for (genvar k = 0; k < p_stages; k++) begin : g_stage
    logic               src_valid;
    logic [p_width-1:0] src_data;
    if (k == 0) begin : g_head
      assign src_valid = i_valid;
      assign src_data  = i_data;
    end else begin : g_body
      assign src_valid = valid[k-1];
      assign src_data  = data[k-1];
    end
    pipeline_elastic_stage #(.p_width(p_width)) u_stage (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .in_valid (src_valid),
      .in_data  (src_data),
      .load     (rdy[k]),
      .flush    (i_flush),
      .valid    (valid[k]),
      .data     (data[k]),
      .valid_nxt(valid_nxt[k])
    );
  end

  always_comb begin
    count_d = '0;
    for (int k = 0; k < p_stages; k++) begin
      count_d = count_d + c_cnt_w'(valid_nxt[k]);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_valid = valid[p_stages-1];
  assign o_data  = data[p_stages-1];
  assign o_count = count_q;

endmodule

// File: tb/tb_pipeline_elastic.sv
// Bench for pipeline_elastic: 8-, 3- and 1-stage instances share stimulus and
// are each compared every cycle against a queue model of words and positions.
module tb_pipeline_elastic;
  import pipeline_pkg::*;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0] data;
    int           pos;
  } ent_t;
  typedef ent_t q_t[$];

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  pipeline_elastic_if #(.p_width(W)) up_if ();
  pipeline_elastic_if #(.p_width(W)) dn_if ();

  logic [3:0]   cnt8;
  logic         ov3, ordy3, ov1, ordy1;
  logic [W-1:0] od3, od1;
  logic [1:0]   cnt3;
  logic [0:0]   cnt1;

  pipeline_elastic #(.p_width(W), .p_stages(8)) u_dut8 (
    .i_clk(clk), .i_rst(rst), .i_valid(up_if.valid), .o_ready(up_if.ready),
    .i_data(up_if.data), .o_valid(dn_if.valid), .i_ready(dn_if.ready),
    .o_data(dn_if.data), .i_flush(flush), .o_count(cnt8)
  );
  pipeline_elastic #(.p_width(W), .p_stages(3)) u_dut3 (
    .i_clk(clk), .i_rst(rst), .i_valid(up_if.valid), .o_ready(ordy3),
    .i_data(up_if.data), .o_valid(ov3), .i_ready(dn_if.ready),
    .o_data(od3), .i_flush(flush), .o_count(cnt3)
  );
  pipeline_elastic #(.p_width(W), .p_stages(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_valid(up_if.valid), .o_ready(ordy1),
    .i_data(up_if.data), .o_valid(ov1), .i_ready(dn_if.ready),
    .o_data(od1), .i_flush(flush), .o_count(cnt1)
  );

  // scoreboard state
  int n_pass = 0;
  int n_total = 0;
  int cyc_n = 0;
  bit lat_on = 1'b0;
  int t_in [int];
  q_t q8, q3, q1;
  logic [W-1:0] out_log [$];
  logic [W-1:0] exp_q [$];
  logic last_ordy8;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  // Reference: a word at position pos advances when the consumer is ready or
  // fewer than (S-1-pos) older words sit ahead of it; the input is taken when
  // not flushing and either the consumer is ready or the pipe is not full.
  task automatic model_step(input string tag, input int s, inout q_t q,
                            input logic ov, input logic ordy,
                            input logic [W-1:0] od, input logic [7:0] cnt);
    logic m_ov, m_ordy, pop;
    ent_t e;
    m_ov   = (q.size() > 0) && (q[0].pos == s - 1);
    m_ordy = !flush && (dn_if.ready || q.size() < s);
    chk({tag, ".o_ready"}, ordy, m_ordy);
    chk({tag, ".o_valid"}, ov, m_ov);
    chk({tag, ".o_count"}, cnt, q.size());
    if (m_ov) chk({tag, ".o_data"}, od, q[0].data);
    pop = m_ov && dn_if.ready;
    for (int i = 0; i < q.size(); i++) begin
      if (dn_if.ready || (s - 1 - q[i].pos) > i) q[i].pos++;
    end
    if (pop) void'(q.pop_front());
    if (flush) begin
      q.delete();
    end else if (up_if.valid && m_ordy) begin
      e.data = up_if.data;
      e.pos  = 0;
      q.push_back(e);
    end
  endtask

  // driver: one clock cycle of stimulus, checked before the rising edge
  task automatic cyc(input bit wait_edge, input logic v, input logic [W-1:0] d,
                     input logic r, input logic f);
    if (wait_edge) @(negedge clk);
    up_if.valid = v;
    up_if.data  = d;
    dn_if.ready = r;
    flush       = f;
    #1;
    last_ordy8 = up_if.ready;
    if (dn_if.valid && dn_if.ready) begin
      out_log.push_back(dn_if.data);
      if (lat_on) chk("latency", cyc_n - t_in[int'(dn_if.data)], 8);
    end
    if (up_if.valid && up_if.ready) t_in[int'(d)] = cyc_n;
    model_step("s8", 8, q8, dn_if.valid, up_if.ready, dn_if.data, {4'b0, cnt8});
    model_step("s3", 3, q3, ov3, ordy3, od3, {6'b0, cnt3});
    model_step("s1", 1, q1, ov1, ordy1, od1, {7'b0, cnt1});
    cyc_n++;
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, ".o_valid8"}, dn_if.valid, 1'b0);
    chk({tag, ".o_count8"}, cnt8, 4'd0);
    chk({tag, ".o_data8"}, dn_if.data, '0);
    chk({tag, ".o_ready8"}, up_if.ready, 1'b1);
    chk({tag, ".o_valid3"}, ov3, 1'b0);
    chk({tag, ".o_count3"}, cnt3, 2'd0);
    chk({tag, ".o_valid1"}, ov1, 1'b0);
    chk({tag, ".o_count1"}, cnt1, 1'b0);
    flush = 1'b1;
    #1;
    chk({tag, ".o_ready_flush8"}, up_if.ready, 1'b0);
    chk({tag, ".o_ready_flush1"}, ordy1, 1'b0);
    flush = 1'b0;
  endtask

  task automatic chk_log(input string tag);
    chk({tag, ".len"}, out_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < out_log.size(); i++)
      chk({tag, ".word"}, out_log[i], exp_q[i]);
    out_log.delete();
    exp_q.delete();
  endtask

  initial begin
    int acc_n;
    int max8;
    up_if.valid = 1'b0;
    up_if.data  = '0;
    dn_if.ready = 1'b0;

    // reset state
    #1;
    chk_cleared("reset");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // streaming, latency 8, occupancy saturates at 8
    lat_on = 1'b1;
    max8 = 0;
    for (int w = 1; w <= 32; w++) begin
      cyc(1, 1'b1, W'(w), 1'b1, 1'b0);
      exp_q.push_back(W'(w));
      if (int'(cnt8) > max8) max8 = int'(cnt8);
    end
    for (int i = 0; i < 10; i++) cyc(1, 1'b0, '0, 1'b1, 1'b0);
    lat_on = 1'b0;
    chk("stream.max_count", max8, 8);
    chk_log("stream");

    // back-pressure fill: exactly 8 accepted, then o_ready low
    acc_n = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1, 1'b1, W'(16'hA0 + acc_n), 1'b0, 1'b0);
      if (last_ordy8) acc_n++;
    end
    chk("fill.accepted", acc_n, 8);
    chk("fill.o_ready", last_ordy8, 1'b0);
    chk("fill.count", cnt8, 4'd8);
    out_log.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(W'(16'hA0 + i));
    for (int i = 0; i < 8; i++) cyc(1, 1'b0, '0, 1'b1, 1'b0);
    chk_log("fill.drain");
    for (int i = 0; i < 4; i++) cyc(1, 1'b0, '0, 1'b1, 1'b0);
    out_log.delete();

    // bubble collapse
    cyc(1, 1'b1, 16'h00B1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1, 1'b0, '0, 1'b0, 1'b0);
    cyc(1, 1'b1, 16'h00B2, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1, 1'b0, '0, 1'b0, 1'b0);
    chk("bubble.count", cnt8, 4'd2);
    chk("bubble.o_valid", dn_if.valid, 1'b1);
    chk("bubble.o_data", dn_if.data, 16'h00B1);
    exp_q.push_back(16'h00B1);
    exp_q.push_back(16'h00B2);
    for (int i = 0; i < 2; i++) cyc(1, 1'b0, '0, 1'b1, 1'b0);
    chk_log("bubble.drain");

    // flush with 6 held words and a word offered
    for (int i = 0; i < 6; i++) cyc(1, 1'b1, W'(16'hC0 + i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1, 1'b0, '0, 1'b0, 1'b0);
    chk("flush.count_before", cnt8, 4'd6);
    cyc(1, 1'b1, 16'h00CF, 1'b0, 1'b1);
    chk("flush.o_ready", last_ordy8, 1'b0);
    cyc(1, 1'b0, '0, 1'b1, 1'b0);
    chk("flush.count_after", cnt8, 4'd0);
    chk("flush.o_valid_after", dn_if.valid, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1, 1'b0, '0, 1'b1, 1'b0);
    chk_log("flush.drain");

    // asynchronous reset with 5 words in flight
    for (int i = 0; i < 5; i++) cyc(1, 1'b1, W'(16'hE0 + i), 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk_cleared("midreset");
    q8.delete();
    q3.delete();
    q1.delete();
    up_if.valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc(0, 1'b1, 16'h00D0, 1'b1, 1'b0);
    chk("midreset.first_accept", last_ordy8, 1'b1);
    for (int i = 1; i < 4; i++) cyc(1, 1'b1, W'(16'hD0 + i), 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) exp_q.push_back(W'(16'hD0 + i));
    for (int i = 0; i < 10; i++) cyc(1, 1'b0, '0, 1'b1, 1'b0);
    chk_log("midreset.drain");

    // random traffic against the model on all three depths
    for (int n = 0; n < 10000; n++) begin
      cyc(1, $urandom_range(0, 99) < 70, W'($urandom), $urandom_range(0, 99) < 60,
          $urandom_range(0, 99) < 3);
    end
    for (int i = 0; i < 10; i++) cyc(1, 1'b0, '0, 1'b1, 1'b0);
    chk("random.empty8", cnt8, 4'd0);
    chk("random.model_empty", q8.size() + q3.size() + q1.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pipeline_elastic.md
# pipeline_elastic

Parametrised elastic pipeline: carries a `p_width`-bit data word through `p_stages` register stages with a valid/ready handshake on both sides.
- Each stage holds data only while its valid bit is set.
- Downstream back-pressure stalls only the stages that cannot advance; bubbles collapse.
- A synchronous flush empties the pipe.
- It replaces fixed-latency, always-advancing delay lines wherever a consumer can stall, and sits between any producer/consumer pair on the same clock.

## Interface
Parameters:
- `p_width`, 32: data word width in bits, ≥1.
- `p_stages`, 8: number of register stages, ≥1.

Ports:
- `i_clk`  in  1  clock, all state on rising edge.
- `i_rst`  in  1  reset, asynchronous, active-high.
- `i_valid`  in  1  upstream word present.
- `o_ready`  out  1  pipe can accept a word this cycle.
- `i_data`  in  `p_width`  upstream word.
- `o_valid`  out  1  last stage holds a word.
- `i_ready`  in  1  downstream accepts the word this cycle.
- `o_data`  out  `p_width`  last stage word.
- `i_flush`  in  1  discard all contents and any word offered this cycle.
- `o_count`  out  `$clog2(p_stages+1)`  number of occupied stages.

## Operation
- **State.** Per stage k (0..`p_stages-1`): a `valid[k]` bit and a `data[k]` register. Stage 0 is the input stage; stage `p_stages-1` drives `o_valid` and `o_data`.
- **Ready chain.** `rdy[p_stages] = i_ready`. For each k, `rdy[k] = !valid[k] || rdy[k+1]`. `o_ready = rdy[0] && !i_flush`.
- **Stage update.** Stage k loads when `rdy[k]`:
  - `valid[k] <= valid[k-1]` and `data[k] <= data[k-1]`.
  - For stage 0, the source is `i_valid`/`i_data` instead of stage k-1.
  - When `!rdy[k]`, the stage holds its value.
- **Data enable.** `data[k]` updates only when the stage loads and the incoming valid is 1. This saves power; bench results must not depend on data contents while a stage's valid bit is 0.
- **Transfers.** An input transfer occurs when `i_valid && o_ready`. An output transfer occurs when `o_valid && i_ready`. A word is never duplicated, dropped (except by flush), or reordered.
- **Flush.** When `i_flush` is 1, all `valid[k]` are 0 after the edge.
  - The word offered on the input that cycle is not accepted, because `o_ready` is 0.
  - The output handshake in the flush cycle still completes if `o_valid && i_ready`.
- **Occupancy.** `o_count` is a register equal to the number of set `valid[k]` after each edge. Range 0..`p_stages`; it never wraps.
- **Reset.** While `i_rst` is high, all `valid[k]` are 0, all `data[k]` are 0 and `o_count` is 0. Therefore `o_valid` = 0, `o_data` = 0, and `o_ready` = `!i_flush`.

## Timing
- **Latency.** With `i_ready` held at 1, a word accepted at edge N appears on `o_valid`/`o_data` after edge N+`p_stages`-1 and is consumed at edge N+`p_stages`.
- **Throughput.** One word per cycle when unstalled.
- **Combinational path.** There is a combinational path from `i_ready` to `o_ready` through `p_stages` OR gates; this is intentional. There is no combinational path from `i_valid` or `i_data` to any output.
- **Full pipe, output stalled.** When all stages are valid and `i_ready` = 0, `o_ready` = 0.
- **Full pipe, simultaneous in/out.** When `i_ready` = 1 in the same cycle, `o_ready` = 1 and in and out transfer together. `o_count` stays at `p_stages`.
- **Bubble collapse.** When `i_ready` = 0, an empty stage anywhere in the pipe is filled from upstream on the next edge.
- **Reset mid-operation.** Asynchronous assertion clears all state immediately. No words survive.
- **Reset release.** First input acceptance is possible at the first edge after `i_rst` deasserts.

## Structure
- **Shared package `pipeline_pkg`:**
  - `function automatic int count_width(int stages)` returning `$clog2(stages+1)`.
  - Parameter-check macros asserting `p_width`≥1 and `p_stages`≥1.
- **Sub-module `pipeline_elastic_stage`:** one `valid`/`data` register pair with inputs `in_valid`, `in_data`, `load`, `flush`. It is instantiated `p_stages` times in a generate loop. The ready chain and the `o_count` popcount live in the top.

## Test plan
- **Reset.** Assert `i_rst` mid-stream with 5 words in flight, `p_stages`=8 → `o_valid`=0, `o_count`=0, `o_data`=0 immediately; after release, new words flow with correct order.
- **Streaming.** `i_ready`=1; drive words 0x1..0x20 back-to-back → each appears exactly 8 cycles after acceptance; `o_count` saturates at 8; order preserved.
- **Back-pressure fill.** `i_ready`=0; offer words 0xA0.. continuously → exactly 8 accepted; `o_ready`=0 from the 9th cycle; `o_count`=8. Releasing `i_ready` drains 0xA0..0xA7 in order at one per cycle.
- **Bubble collapse.** Insert 3 idle cycles between words A and B, then hold `i_ready`=0 → B joins directly behind A; `o_count`=2; no gaps when drained.
- **Flush.** Assert `i_flush` with 6 words held and `i_valid`=1 → `o_ready`=0 that cycle; the next cycle shows `o_count`=0 and `o_valid`=0. The offered word is absent from the output.
- **Random compare, `p_stages`=1 and 3.** Random `i_valid`/`i_ready`/`i_flush` over 10k cycles, checked against a queue model → no loss, duplication or reorder; `o_count` always matches the model.
